// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle mult/multu/div/divu unit with HI/LO registers
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, plus mthi/mtlo.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   a_orig;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quo, rmd;

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_comb begin
    a_neg = ~op[0] & inA[WIDTH-1];
    b_neg = ~op[0] & inB[WIDTH-1];
    a_abs = a_neg ? -inA : inA;
    b_abs = b_neg ? -inB : inB;

    // acc low half holds the operand being consumed (multiplier / dividend bits)
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // acc high half is the partial remainder; a borrow in diff[WIDTH] means restore
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = trial - {1'b0, b_mag};
    div_next = diff[WIDTH] ? {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rmd  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      acc         <= '0;
      b_mag       <= '0;
      a_orig      <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            count   <= '0;
            acc     <= {{WIDTH{1'b0}}, a_abs};
            b_mag   <= b_abs;
            a_orig  <= inA;
            is_div  <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (inB == '0);
          end else begin
            state <= S_IDLE;
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (count == LAST) begin
            // final cycle: sign fix-up and result write
            state       <= S_DONE;
            div_by_zero <= is_div & b_zero;
            if (!is_div) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (b_zero) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= rmd;
              lo <= quo;
            end
          end else begin
            count <= count + ONE;
            acc   <= is_div ? div_next : mul_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
// Directed vectors, hand-written corner sequences and random ops against an arithmetic model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  inA = '0;
  logic [W-1:0]  inB = '0;
  logic          flush = 1'b0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_fail = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    logic [63:0] p;
    longint sa, sb;
    int q, r;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = sa * sb;
        h = p[63:32];
        l = p[31:0];
      end
      2'd1: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      2'd2: begin
        if (b == 0) begin
          h = a; l = 32'hffffffff; z = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hffffffff) begin
          h = 0; l = 32'h80000000;
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          l = q;
          h = r;
        end
      end
      default: begin
        if (b == 0) begin
          h = a; l = 32'hffffffff; z = 1'b1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  // Call just after a negedge; returns at the negedge where busy has dropped.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output bit early_done);
    op = o; inA = a; inB = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    inA = $urandom;
    inB = $urandom;
    op = 2'($urandom);
    cyc = 0;
    early_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busy) break;
      cyc++;
      if (done) early_done = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] eh, input logic [31:0] el,
                              input logic ez, input int cyc, input bit early_done);
    check({tag, " busy_cycles"}, cyc, W + 1);
    check({tag, " done"}, done, 1);
    check({tag, " done_while_busy"}, early_done, 0);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " div_by_zero"}, div_by_zero, ez);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    bit          chain;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int cyc;
    bit ed;
    int done_seen;
    logic [31:0] eh, el, ra, rb;
    logic ez;
    logic [1:0] ro;
    bit chain;

    vecs[0]  = '{2'd1, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 1'b0, 1'b0};
    vecs[1]  = '{2'd0, 32'hfffffff9, 32'd6,        32'hffffffff, 32'hffffffd6, 1'b0, 1'b0};
    vecs[2]  = '{2'd2, 32'hfffffff9, 32'd2,        32'hffffffff, 32'hfffffffd, 1'b0, 1'b0};
    vecs[3]  = '{2'd3, 32'd100,      32'd0,        32'd100,      32'hffffffff, 1'b1, 1'b0};
    vecs[4]  = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0};
    vecs[5]  = '{2'd2, 32'h80000000, 32'hffffffff, 32'd0,        32'h80000000, 1'b0, 1'b1};
    vecs[6]  = '{2'd1, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 1'b0};
    vecs[7]  = '{2'd2, 32'd7,        32'hfffffffe, 32'd1,        32'hfffffffd, 1'b0, 1'b0};
    vecs[8]  = '{2'd3, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0, 1'b0};
    vecs[9]  = '{2'd2, 32'hffffffff, 32'd0,        32'hffffffff, 32'hffffffff, 1'b1, 1'b1};
    vecs[10] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset div_by_zero", div_by_zero, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, ed);
      check_result($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo, vecs[i].dbz, cyc, ed);
      if (!vecs[i].chain) begin
        @(negedge clock);
        check($sformatf("vec%0d done_pulse_width", i), done, 0);
      end
    end

    // mthi / mtlo, both together then HI alone
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000a5a5;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo hi", hi, 32'h0000a5a5);
    check("mthi_mtlo lo", lo, 32'h0000a5a5);
    hi_we = 1'b1; wdata = 32'h00001234;
    @(negedge clock);
    hi_we = 1'b0;
    check("mthi hi", hi, 32'h00001234);
    check("mthi lo_kept", lo, 32'h0000a5a5);

    // MULT flushed after 10 cycles, with an ignored mthi while busy
    op = 2'd0; inA = 32'd1000; inB = 32'd1000; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 4) begin hi_we = 1'b1; wdata = 32'h0000beef; end
      if (i == 5) hi_we = 1'b0;
      if (i == 10) flush = 1'b1;
    end
    check("flush busy_before", busy, 1);
    check("mthi_while_busy hi", hi, 32'h00001234);
    @(negedge clock);
    flush = 1'b0;
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    check("flush hi", hi, 32'h00001234);
    check("flush lo", lo, 32'h0000a5a5);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    check("flush no_done", done_seen, 0);

    // start wins over mthi on the same edge
    op = 2'd1; inA = 32'd3; inB = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h00000099;
    @(posedge clock);
    #1;
    start = 1'b0; hi_we = 1'b0;
    @(negedge clock);
    check("start_prio busy", busy, 1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("start_prio idle", busy, 0);
    check("start_prio hi", hi, 32'h00001234);

    // asynchronous reset in the middle of a DIV
    op = 2'd2; inA = 32'd1000; inB = 32'd3; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset div_by_zero", div_by_zero, 0);
    check("midreset hi", hi, 0);
    check("midreset lo", lo, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("postreset idle", busy, 0);
    run_op(2'd1, 32'd3, 32'd5, cyc, ed);
    check_result("postreset multu", 32'd0, 32'd15, 1'b0, cyc, ed);
    @(negedge clock);

    // random ops against the arithmetic model
    for (int n = 0; n < 60; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hffffffff;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      chain = bit'($urandom_range(0, 1));
      model(ro, ra, rb, eh, el, ez);
      run_op(ro, ra, rb, cyc, ed);
      check_result($sformatf("rand%0d op%0d a=%0h b=%0h", n, ro, ra, rb), eh, el, ez, cyc, ed);
      if (!chain) begin
        @(negedge clock);
        check($sformatf("rand%0d done_pulse_width", n), done, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
